// File: rtl/register_bank.sv
// register_bank: 32 x WIDTH MIPS register file, two combinational read ports, one write port, optional write-to-read bypass
module register_bank #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] SP_INIT = WIDTH'(32'h000003FC),
    parameter logic [WIDTH-1:0] GP_INIT = WIDTH'(32'h10008000),
    parameter int               BYPASS  = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       readRegister1,
    input  logic [4:0]       readRegister2,
    input  logic [4:0]       writeRegister,
    input  logic [WIDTH-1:0] writeData,
    input  logic             regWrite,
    output logic [WIDTH-1:0] readData1,
    output logic [WIDTH-1:0] readData2
);
    logic [WIDTH-1:0] regs [1:31];
    logic             wr_en;
    logic             hit1;
    logic             hit2;
    assign wr_en = regWrite && writeRegister != 5'd0;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++)
                regs[i] <= (i == 28) ? GP_INIT : (i == 29) ? SP_INIT : '0;
        end else if (wr_en) begin
            regs[writeRegister] <= writeData;
        end
    end
    // forwarding is suppressed under reset because the write it would preview is discarded
    assign hit1 = BYPASS != 0 && !reset && wr_en && writeRegister == readRegister1;
    assign hit2 = BYPASS != 0 && !reset && wr_en && writeRegister == readRegister2;
    assign readData1 = hit1 ? writeData : (readRegister1 == 5'd0) ? '0 : regs[readRegister1];
    assign readData2 = hit2 ? writeData : (readRegister2 == 5'd0) ? '0 : regs[readRegister2];
endmodule
